// File: rtl/ahb_vga_char_writer.sv
// AHB-Lite master that drains a small character FIFO into the AHBVGA console register.
// Optional build macro AHB_VGA_CHAR_WRITER_VSYNC_GATE_EN adds vsync_blank to gate transfer starts.
module ahb_vga_char_writer #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
  parameter int          MIN_GAP   = 2,
  parameter int          CNT_W     = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
`ifdef AHB_VGA_CHAR_WRITER_VSYNC_GATE_EN
  input  logic             vsync_blank,
`endif
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             busy,
  output logic [CNT_W-1:0] tx_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_next;
  logic             push;
  logic             pop;
  logic             gate_open;

`ifdef AHB_VGA_CHAR_WRITER_VSYNC_GATE_EN
  assign gate_open = vsync_blank;
`else
  assign gate_open = 1'b1;
`endif

  // Ready depends only on the stored count, so a pop while full never frees a slot in the same cycle.
  assign char_ready = (count < FULL_COUNT);
  assign push       = char_valid && char_ready;
  assign busy       = (count != '0) || (state != IDLE);
  assign HSIZE      = 3'b010;

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= char_data;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      gap_cnt  <= '0;
      tx_count <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
      if (pop) begin
        tx_count <= tx_count + CNT_W'(1);
      end
    end
  end

  // The head is only popped when its data phase completes, keeping HWDATA stable across wait states.
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    pop          = 1'b0;
    HTRANS       = 2'b00;
    HWRITE       = 1'b0;
    HADDR        = '0;
    HWDATA       = '0;
    case (state)
      IDLE: begin
        if ((count != '0) && gate_open) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = BASE_ADDR;
        if (HREADY) begin
          state_next = DATA;
        end
      end
      DATA: begin
        HWDATA = {24'h0, mem[rd_ptr]};
        if (HREADY) begin
          pop          = 1'b1;
          gap_cnt_next = GAP_W'(MIN_GAP);
          state_next   = (MIN_GAP == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
